// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// opcode constants, datapath mux/ALU encodings and the opcode class record.
// The optional J instruction is enabled by defining MCU_JUMP_EN.
package mcu_pkg;

    // Four-bit state codes; the numeric value is exported on the debug port.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_I_EXEC   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd15
    } state_t;

    // Opcode constants (IR[31:26]); zero-extended when OPCODE_W > 6.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operand B select.
    localparam logic [1:0] SRC_B_RT      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // Next-PC source select (only exported when MCU_JUMP_EN is defined).
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // One-hot-ish instruction class produced by mcu_opcode_class.
    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic addi;
        logic beq;
        logic jump;
        logic illegal;
    } op_class_t;

    // States in which the unit waits on the memory ready handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mcu_opcode_class.sv
// Combinational opcode classifier. J (0x02) is recognised only when
// MCU_JUMP_EN is defined; otherwise it falls into the illegal class.
module mcu_opcode_class
    import mcu_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           cls
);

    // Decode the opcode into its instruction class; anything unmatched is illegal.
    always_comb begin
        cls       = '0;
        cls.load  = (opcode == OPCODE_W'(OP_LW)) ||
                    (opcode == OPCODE_W'(OP_LH)) ||
                    (opcode == OPCODE_W'(OP_LHU));
        cls.store = (opcode == OPCODE_W'(OP_SW));
        cls.rtype = (opcode == OPCODE_W'(OP_RTYPE));
        cls.addi  = (opcode == OPCODE_W'(OP_ADDI));
        cls.beq   = (opcode == OPCODE_W'(OP_BEQ));
`ifdef MCU_JUMP_EN
        cls.jump  = (opcode == OPCODE_W'(OP_J));
`else
        cls.jump  = 1'b0;
`endif
        cls.illegal = !(cls.load | cls.store | cls.rtype | cls.addi | cls.beq | cls.jump);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback, stalls on mem_ready, and traps on illegal opcodes or on a
// memory access that waits TIMEOUT cycles (TIMEOUT = 0 disables the check).
// Defining MCU_JUMP_EN adds the J instruction and the pc_src output.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  IDLE      | one cycle after reset, nothing driven
//  FETCH     | read instruction at PC, PC+4; waits for mem_ready
//  DECODE    | latch opcode, precompute branch target, dispatch
//  MEM_ADDR  | effective address rs + sign-ext imm
//  MEM_RD    | data read at ALUOut; waits for mem_ready
//  MEM_WB    | write MDR to rt
//  MEM_WR    | data write at ALUOut; waits for mem_ready
//  R_EXEC    | rs funct rt
//  R_WB      | write ALUOut to rd
//  I_EXEC    | rs + sign-ext imm
//  I_WB      | write ALUOut to rt
//  BRANCH    | rs - rt, PC <= ALUOut when zero
//  JUMP      | PC <= jump target (MCU_JUMP_EN only)
//  TRAP      | illegal opcode or memory timeout; left only by rst
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                load_full,
    output logic                load_signed,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                pc_en,
`ifdef MCU_JUMP_EN
    output logic [1:0]          pc_src,
`endif
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic                store_q;
    op_class_t           cls;
    logic [CNT_W-1:0]    wait_left;
    logic                wait_expired;
    logic                illegal_q;
    logic                timeout_q;
    logic                pc_write;
    logic                pc_write_cond;
    logic                is_load_ph;

    mcu_opcode_class #(
        .OPCODE_W (OPCODE_W)
    ) u_opcode_class (
        .opcode (opcode),
        .cls    (cls)
    );

    // Last permitted stall cycle of a memory access; a ready in that cycle still completes.
    assign wait_expired = (TIMEOUT != 0) && is_wait_state(state_q) && !mem_ready &&
                          (wait_left == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)         state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                if (cls.load || cls.store) state_d = ST_MEM_ADDR;
                else if (cls.rtype)        state_d = ST_R_EXEC;
                else if (cls.addi)         state_d = ST_I_EXEC;
                else if (cls.beq)          state_d = ST_BRANCH;
                else if (cls.jump)         state_d = ST_JUMP;
                else                       state_d = ST_TRAP;
            end
            ST_MEM_ADDR: state_d = store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)         state_d = ST_MEM_WB;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready)         state_d = ST_FETCH;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_R_WB:     state_d = ST_FETCH;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_I_WB:     state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Latched opcode, stall down-counter and sticky trap causes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            store_q   <= 1'b0;
            wait_left <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_DECODE) begin
                op_q    <= opcode;
                store_q <= cls.store;
                if (cls.illegal) illegal_q <= 1'b1;
            end
            if (state_d != state_q) begin
                wait_left <= CNT_W'(TIMEOUT);
            end else if (is_wait_state(state_q) && !mem_ready) begin
                wait_left <= wait_left - CNT_W'(1);
            end
            if (wait_expired) timeout_q <= 1'b1;
        end
    end

    // Halfword and word loads share the memory path; width and sign follow op_q.
    assign is_load_ph = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WB);

    // Moore datapath controls; only ir_write and pc_en look at live inputs.
    always_comb begin
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        alu_op        = ALU_ADD;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
`ifdef MCU_JUMP_EN
        pc_src        = PC_SRC_ALU;
`endif
        load_full     = is_load_ph && (op_q == OPCODE_W'(OP_LW));
        load_signed   = is_load_ph && ((op_q == OPCODE_W'(OP_LW)) ||
                                       (op_q == OPCODE_W'(OP_LH)));
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
            end
            ST_MEM_ADDR, ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
`ifdef MCU_JUMP_EN
                pc_src        = PC_SRC_ALUOUT;
`endif
            end
            ST_JUMP: begin
                pc_write = 1'b1;
`ifdef MCU_JUMP_EN
                pc_src   = PC_SRC_JUMP;
`endif
            end
            default: begin
            end
        endcase
    end

    assign pc_en      = pc_write | (pc_write_cond & alu_zero);
    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. Instance 0 uses the default
// TIMEOUT of 16, instance 1 uses TIMEOUT = 4 for the stall-limit cases.
module tb_multicycle_control_unit;
    import mcu_pkg::*;

    localparam int OPCODE_W = 6;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       load_full;
        logic       load_signed;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_en;
        logic       illegal_op;
        logic       timeout;
    } obs_t;

    typedef struct {
        obs_t  v;
        int    dut;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst;
    logic [1:0]          mem_ready;
    logic [1:0]          alu_zero;
    logic [OPCODE_W-1:0] opcode [2];
    logic [1:0]          ir_write, i_or_d, mem_read, mem_write, load_full, load_signed;
    logic [1:0]          mem_to_reg, reg_dst, reg_write, alu_src_a, pc_en, illegal_op, timeout;
    logic [1:0]          alu_src_b [2];
    logic [1:0]          alu_op [2];
    logic [3:0]          state [2];
`ifdef MCU_JUMP_EN
    logic [1:0]          pc_src [2];
`endif

    multicycle_control_unit #(.OPCODE_W(OPCODE_W), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst[0]), .opcode(opcode[0]), .mem_ready(mem_ready[0]),
        .alu_zero(alu_zero[0]), .ir_write(ir_write[0]), .i_or_d(i_or_d[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .load_full(load_full[0]),
        .load_signed(load_signed[0]), .mem_to_reg(mem_to_reg[0]), .reg_dst(reg_dst[0]),
        .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .alu_op(alu_op[0]), .pc_en(pc_en[0]),
`ifdef MCU_JUMP_EN
        .pc_src(pc_src[0]),
`endif
        .state(state[0]), .illegal_op(illegal_op[0]), .timeout(timeout[0])
    );

    multicycle_control_unit #(.OPCODE_W(OPCODE_W), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst[1]), .opcode(opcode[1]), .mem_ready(mem_ready[1]),
        .alu_zero(alu_zero[1]), .ir_write(ir_write[1]), .i_or_d(i_or_d[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .load_full(load_full[1]),
        .load_signed(load_signed[1]), .mem_to_reg(mem_to_reg[1]), .reg_dst(reg_dst[1]),
        .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .alu_op(alu_op[1]), .pc_en(pc_en[1]),
`ifdef MCU_JUMP_EN
        .pc_src(pc_src[1]),
`endif
        .state(state[1]), .illegal_op(illegal_op[1]), .timeout(timeout[1])
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected output vectors per state, written from the behaviour description.
    function automatic obs_t o_zero();
        obs_t o = '0;
        return o;
    endfunction
    function automatic obs_t o_fetch(input logic mr);
        obs_t o = '0;
        o.st = ST_FETCH; o.mem_read = 1'b1; o.alu_src_b = 2'd1;
        o.ir_write = mr; o.pc_en = mr;
        return o;
    endfunction
    function automatic obs_t o_decode();
        obs_t o = '0;
        o.st = ST_DECODE; o.alu_src_b = 2'd3;
        return o;
    endfunction
    function automatic obs_t o_maddr();
        obs_t o = '0;
        o.st = ST_MEM_ADDR; o.alu_src_a = 1'b1; o.alu_src_b = 2'd2;
        return o;
    endfunction
    function automatic obs_t o_mrd(input logic lf, input logic ls);
        obs_t o = '0;
        o.st = ST_MEM_RD; o.mem_read = 1'b1; o.i_or_d = 1'b1;
        o.load_full = lf; o.load_signed = ls;
        return o;
    endfunction
    function automatic obs_t o_mwb(input logic lf, input logic ls);
        obs_t o = '0;
        o.st = ST_MEM_WB; o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        o.load_full = lf; o.load_signed = ls;
        return o;
    endfunction
    function automatic obs_t o_mwr();
        obs_t o = '0;
        o.st = ST_MEM_WR; o.mem_write = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_rex();
        obs_t o = '0;
        o.st = ST_R_EXEC; o.alu_src_a = 1'b1; o.alu_op = 2'd2;
        return o;
    endfunction
    function automatic obs_t o_rwb();
        obs_t o = '0;
        o.st = ST_R_WB; o.reg_write = 1'b1; o.reg_dst = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_iex();
        obs_t o = '0;
        o.st = ST_I_EXEC; o.alu_src_a = 1'b1; o.alu_src_b = 2'd2;
        return o;
    endfunction
    function automatic obs_t o_iwb();
        obs_t o = '0;
        o.st = ST_I_WB; o.reg_write = 1'b1;
        return o;
    endfunction
    function automatic obs_t o_br(input logic az);
        obs_t o = '0;
        o.st = ST_BRANCH; o.alu_src_a = 1'b1; o.alu_op = 2'd1; o.pc_en = az;
        return o;
    endfunction
`ifdef MCU_JUMP_EN
    function automatic obs_t o_jump();
        obs_t o = '0;
        o.st = ST_JUMP; o.pc_en = 1'b1;
        return o;
    endfunction
`endif
    function automatic obs_t o_trap(input logic ill, input logic to);
        obs_t o = '0;
        o.st = ST_TRAP; o.illegal_op = ill; o.timeout = to;
        return o;
    endfunction

    function automatic obs_t sample(input int d);
        obs_t o;
        o.st = state[d];           o.ir_write = ir_write[d];
        o.i_or_d = i_or_d[d];      o.mem_read = mem_read[d];
        o.mem_write = mem_write[d]; o.load_full = load_full[d];
        o.load_signed = load_signed[d]; o.mem_to_reg = mem_to_reg[d];
        o.reg_dst = reg_dst[d];    o.reg_write = reg_write[d];
        o.alu_src_a = alu_src_a[d]; o.alu_src_b = alu_src_b[d];
        o.alu_op = alu_op[d];      o.pc_en = pc_en[d];
        o.illegal_op = illegal_op[d]; o.timeout = timeout[d];
        return o;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic cyc(input int d, input logic r, input logic mr, input logic az,
                       input logic [5:0] op, input obs_t e, input string tag);
        exp_t x;
        rst[d]       = r;
        mem_ready[d] = mr;
        alu_zero[d]  = az;
        opcode[d]    = OPCODE_W'(op);
        x.v = e; x.dut = d; x.tag = tag;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the presented outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        obs_t a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = sample(e.dut);
            n_checks++;
            if (a !== e.v) begin
                n_fail++;
                $display("FAIL %s dut%0d: actual state=%0d vec=%h, required state=%0d vec=%h",
                         e.tag, e.dut, a.st, a, e.v.st, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; mem_ready = 2'b00; alu_zero = 2'b00;
        opcode[0] = '0; opcode[1] = '0;
        @(posedge clk); #1;

        // Reset, then IDLE for one cycle and FETCH with ir_write
        cyc(0, 1, 1, 0, OP_LW, o_zero(), "reset_outputs");
        cyc(0, 0, 1, 0, OP_LW, o_zero(), "idle");
        // LW, no stalls: 5 cycles
        cyc(0, 0, 1, 0, OP_LW, o_fetch(1), "lw_fetch");
        cyc(0, 0, 1, 0, OP_LW, o_decode(), "lw_decode");
        cyc(0, 0, 1, 0, OP_LW, o_maddr(), "lw_maddr");
        cyc(0, 0, 1, 0, OP_LW, o_mrd(1, 1), "lw_mrd");
        cyc(0, 0, 1, 0, OP_LW, o_mwb(1, 1), "lw_mwb");
        // LHU with three stall cycles in MEM_RD: 8 cycles
        cyc(0, 0, 1, 0, OP_LHU, o_fetch(1), "lhu_fetch");
        cyc(0, 0, 1, 0, OP_LHU, o_decode(), "lhu_decode");
        cyc(0, 0, 1, 0, OP_LHU, o_maddr(), "lhu_maddr");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, OP_LHU, o_mrd(0, 0), "lhu_mrd_stall");
        cyc(0, 0, 1, 0, OP_LHU, o_mrd(0, 0), "lhu_mrd_done");
        cyc(0, 0, 1, 0, OP_LHU, o_mwb(0, 0), "lhu_mwb");
        // LH: halfword, signed
        cyc(0, 0, 1, 0, OP_LH, o_fetch(1), "lh_fetch");
        cyc(0, 0, 1, 0, OP_LH, o_decode(), "lh_decode");
        cyc(0, 0, 1, 0, OP_LH, o_maddr(), "lh_maddr");
        cyc(0, 0, 1, 0, OP_LH, o_mrd(0, 1), "lh_mrd");
        cyc(0, 0, 1, 0, OP_LH, o_mwb(0, 1), "lh_mwb");
        // BEQ taken and not taken: 3 cycles each
        cyc(0, 0, 1, 1, OP_BEQ, o_fetch(1), "beq_t_fetch");
        cyc(0, 0, 1, 1, OP_BEQ, o_decode(), "beq_t_decode");
        cyc(0, 0, 1, 1, OP_BEQ, o_br(1), "beq_taken");
        cyc(0, 0, 1, 0, OP_BEQ, o_fetch(1), "beq_n_fetch");
        cyc(0, 0, 1, 0, OP_BEQ, o_decode(), "beq_n_decode");
        cyc(0, 0, 1, 0, OP_BEQ, o_br(0), "beq_not_taken");
        // ADDI, R-type, SW: 4 cycles each
        cyc(0, 0, 1, 0, OP_ADDI, o_fetch(1), "addi_fetch");
        cyc(0, 0, 1, 0, OP_ADDI, o_decode(), "addi_decode");
        cyc(0, 0, 1, 0, OP_ADDI, o_iex(), "addi_exec");
        cyc(0, 0, 1, 0, OP_ADDI, o_iwb(), "addi_wb");
        cyc(0, 0, 1, 0, OP_RTYPE, o_fetch(1), "r_fetch");
        cyc(0, 0, 1, 0, OP_RTYPE, o_decode(), "r_decode");
        cyc(0, 0, 1, 0, OP_RTYPE, o_rex(), "r_exec");
        cyc(0, 0, 1, 0, OP_RTYPE, o_rwb(), "r_wb");
        cyc(0, 0, 1, 0, OP_SW, o_fetch(1), "sw_fetch");
        cyc(0, 0, 1, 0, OP_SW, o_decode(), "sw_decode");
        cyc(0, 0, 1, 0, OP_SW, o_maddr(), "sw_maddr");
        cyc(0, 0, 1, 0, OP_SW, o_mwr(), "sw_mwr");
        // Fetch stall, then illegal opcode 0x3F: sticky trap
        cyc(0, 0, 0, 0, 6'h3F, o_fetch(0), "fetch_stall");
        cyc(0, 0, 0, 0, 6'h3F, o_fetch(0), "fetch_stall");
        cyc(0, 0, 1, 0, 6'h3F, o_fetch(1), "ill_fetch");
        cyc(0, 0, 1, 0, 6'h3F, o_decode(), "ill_decode");
        cyc(0, 0, 1, 1, OP_LW, o_trap(1, 0), "ill_trap");
        cyc(0, 0, 1, 1, OP_LW, o_trap(1, 0), "ill_trap_held");
        // Reset leaves TRAP; then opcode 0x02
        cyc(0, 1, 1, 0, OP_J, o_zero(), "trap_reset");
        cyc(0, 0, 1, 0, OP_J, o_zero(), "idle2");
        cyc(0, 0, 1, 0, OP_J, o_fetch(1), "j_fetch");
        cyc(0, 0, 1, 0, OP_J, o_decode(), "j_decode");
`ifdef MCU_JUMP_EN
        cyc(0, 0, 1, 0, OP_J, o_jump(), "j_jump");
        cyc(0, 0, 1, 0, OP_J, o_fetch(1), "j_next_fetch");
`else
        cyc(0, 0, 1, 0, OP_J, o_trap(1, 0), "j_illegal_trap");
`endif
        // Reset aborting a stalled load
        cyc(0, 1, 1, 0, OP_LW, o_zero(), "reset3");
        cyc(0, 0, 1, 0, OP_LW, o_zero(), "idle3");
        cyc(0, 0, 1, 0, OP_LW, o_fetch(1), "abort_fetch");
        cyc(0, 0, 1, 0, OP_LW, o_decode(), "abort_decode");
        cyc(0, 0, 1, 0, OP_LW, o_maddr(), "abort_maddr");
        cyc(0, 0, 0, 0, OP_LW, o_mrd(1, 1), "abort_mrd_stall");
        cyc(0, 1, 0, 0, OP_LW, o_zero(), "abort_reset");
        cyc(0, 0, 1, 0, OP_LW, o_zero(), "abort_idle");
        cyc(0, 0, 1, 0, OP_LW, o_fetch(1), "abort_refetch");

        // TIMEOUT = 4: SW stalls four cycles in MEM_WR and traps
        cyc(1, 1, 1, 0, OP_SW, o_zero(), "b_reset");
        cyc(1, 0, 1, 0, OP_SW, o_zero(), "b_idle");
        cyc(1, 0, 1, 0, OP_SW, o_fetch(1), "b_sw_fetch");
        cyc(1, 0, 1, 0, OP_SW, o_decode(), "b_sw_decode");
        cyc(1, 0, 1, 0, OP_SW, o_maddr(), "b_sw_maddr");
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 0, OP_SW, o_mwr(), "b_sw_mwr_stall");
        cyc(1, 0, 0, 0, OP_SW, o_trap(0, 1), "b_timeout_trap");
        cyc(1, 0, 1, 0, OP_SW, o_trap(0, 1), "b_timeout_held");
        // Ready on the last allowed stall cycle completes; then fetch times out
        cyc(1, 1, 1, 0, OP_SW, o_zero(), "b_reset2");
        cyc(1, 0, 1, 0, OP_SW, o_zero(), "b_idle2");
        cyc(1, 0, 1, 0, OP_SW, o_fetch(1), "b_sw2_fetch");
        cyc(1, 0, 1, 0, OP_SW, o_decode(), "b_sw2_decode");
        cyc(1, 0, 1, 0, OP_SW, o_maddr(), "b_sw2_maddr");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, OP_SW, o_mwr(), "b_sw2_mwr_stall");
        cyc(1, 0, 1, 0, OP_SW, o_mwr(), "b_sw2_ready_wins");
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 0, 0, OP_SW, o_fetch(0), "b_fetch_stall");
        cyc(1, 0, 0, 0, OP_SW, o_trap(0, 1), "b_fetch_timeout");

        repeat (2) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
